// File: rtl/axi4_mem_responder.sv
// rtl/axi4_mem_responder.sv - AXI4 slave backed by a 64-bit memory window, INCR bursts, SLVERR signalling
module axi4_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter int          ADDR_BITS = 21
) (
  input  logic        clk_100Mhz,
  input  logic        rst,
  input  logic        stall_en,
  // write address channel
  input  logic [31:0] s_awaddr,
  input  logic [7:0]  s_awlen,
  input  logic [2:0]  s_awsize,
  input  logic [1:0]  s_awburst,
  input  logic        s_awvalid,
  output logic        s_awready,
  // write data channel
  input  logic [63:0] s_wdata,
  input  logic [7:0]  s_wstrb,
  input  logic        s_wlast,
  input  logic        s_wvalid,
  output logic        s_wready,
  // write response channel
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  // read address channel
  input  logic [31:0] s_araddr,
  input  logic [7:0]  s_arlen,
  input  logic [2:0]  s_arsize,
  input  logic [1:0]  s_arburst,
  input  logic        s_arvalid,
  output logic        s_arready,
  // read data channel
  output logic [63:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic        s_rvalid,
  input  logic        s_rready,
  // diagnostics
  output logic [15:0] err_count
);

  localparam int          IDX_BITS    = ADDR_BITS - 3;
  localparam int          DEPTH       = 1 << IDX_BITS;
  localparam logic [32:0] WIN         = 33'd1 << ADDR_BITS;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_BURST}        r_state_t;

  // A burst is served only if it is INCR of 8-byte beats, both its first
  // and last beat fall inside the window, and it stays within one 4 KiB page.
  function automatic logic burst_legal(input logic [31:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
    logic [32:0] start_off;
    logic [32:0] end_off;
    logic [32:0] last_addr;
    start_off = {1'b0, addr} - {1'b0, BASE_ADDR};
    end_off   = start_off + {22'd0, len, 3'b000};
    last_addr = {1'b0, addr} + {22'd0, len, 3'b000};
    burst_legal = (burst == 2'b01) && (size == 3'b011) &&
                  (start_off < WIN) && (end_off < WIN) &&
                  (last_addr[32:12] == {1'b0, addr[31:12]});
  endfunction

  // Word index inside the window; the low three byte-address bits drop out.
  function automatic logic [IDX_BITS-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    word_idx = IDX_BITS'(off >> 3);
  endfunction

  logic [63:0] mem [DEPTH];

  w_state_t            w_state, w_next;
  r_state_t            r_state, r_next;
  logic                alive;
  logic                phase;
  logic                beat_slot;

  logic [IDX_BITS-1:0] w_idx;
  logic [7:0]          w_len;
  logic [7:0]          w_cnt;
  logic                w_legal;
  logic                w_lastbad;

  logic [IDX_BITS-1:0] r_idx;
  logic [8:0]          r_left;
  logic                r_legal;

  logic aw_fire, w_fire, w_final, b_fire, ar_fire, r_fire, r_load;
  logic w_err_fire, ar_err_fire;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  // Under stall_en only odd-phase cycles may move a W beat or present a new R beat.
  assign beat_slot = !stall_en || phase;

  assign aw_fire = s_awvalid && s_awready;
  assign w_fire  = s_wvalid && s_wready;
  assign w_final = (w_cnt == w_len);
  assign b_fire  = s_bvalid && s_bready;
  assign ar_fire = s_arvalid && s_arready;
  assign r_fire  = s_rvalid && s_rready;

  // A new read beat is fetched whenever the output register is free or draining this cycle.
  assign r_load = (r_state == R_BURST) && (r_left != 9'd0) &&
                  (!s_rvalid || s_rready) && beat_slot;

  assign w_err_fire  = w_fire && w_final && (!w_legal || w_lastbad || !s_wlast);
  assign ar_err_fire = ar_fire && !burst_legal(s_araddr, s_arlen, s_arsize, s_arburst);
  assign err_inc     = {1'b0, w_err_fire} + {1'b0, ar_err_fire};
  assign err_sum     = {1'b0, err_count} + {15'd0, err_inc};

  // Handshake readiness stays low through reset and comes up the first cycle after.
  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      alive <= 1'b0;
      phase <= 1'b0;
    end else begin
      alive <= 1'b1;
      phase <= ~phase;
    end
  end

  // Write FSM state register.
  always_ff @(posedge clk_100Mhz) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // Write FSM next state and channel handshake outputs.
  always_comb begin
    w_next    = w_state;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_awready = alive;
        if (aw_fire) w_next = W_DATA;
      end
      W_DATA: begin
        s_wready = beat_slot;
        if (w_fire && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (b_fire) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write burst bookkeeping: the burst ends on beat count, WLAST only grades the response.
  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      w_idx     <= '0;
      w_len     <= 8'd0;
      w_cnt     <= 8'd0;
      w_legal   <= 1'b0;
      w_lastbad <= 1'b0;
      s_bresp   <= RESP_OKAY;
    end else begin
      if (aw_fire) begin
        w_idx     <= word_idx(s_awaddr);
        w_len     <= s_awlen;
        w_cnt     <= 8'd0;
        w_legal   <= burst_legal(s_awaddr, s_awlen, s_awsize, s_awburst);
        w_lastbad <= 1'b0;
      end
      if (w_fire) begin
        w_idx <= w_idx + IDX_BITS'(1);
        w_cnt <= w_cnt + 8'd1;
        if (s_wlast != w_final) w_lastbad <= 1'b1;
        if (w_final) s_bresp <= w_err_fire ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Byte-strobed memory write; array has no reset so contents survive rst.
  always_ff @(posedge clk_100Mhz) begin
    if (w_fire && w_legal && !rst) begin
      for (int i = 0; i < 8; i++) begin
        if (s_wstrb[i]) mem[w_idx][8*i +: 8] <= s_wdata[8*i +: 8];
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk_100Mhz) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // Read FSM next state and address-channel readiness.
  always_comb begin
    r_next    = r_state;
    s_arready = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_arready = alive;
        if (ar_fire) r_next = R_BURST;
      end
      R_BURST: begin
        if (r_fire && s_rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read burst bookkeeping: next word to fetch and beats still to fetch.
  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      r_idx   <= '0;
      r_left  <= 9'd0;
      r_legal <= 1'b0;
    end else if (ar_fire) begin
      r_idx   <= word_idx(s_araddr);
      r_left  <= {1'b0, s_arlen} + 9'd1;
      r_legal <= burst_legal(s_araddr, s_arlen, s_arsize, s_arburst);
    end else if (r_load) begin
      r_idx  <= r_idx + IDX_BITS'(1);
      r_left <= r_left - 9'd1;
    end
  end

  // Read output register doubles as the synchronous memory read port (read-first vs. writes).
  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      s_rvalid <= 1'b0;
      s_rdata  <= 64'd0;
      s_rresp  <= RESP_OKAY;
      s_rlast  <= 1'b0;
    end else if (r_load) begin
      s_rvalid <= 1'b1;
      s_rdata  <= r_legal ? mem[r_idx] : 64'd0;
      s_rresp  <= r_legal ? RESP_OKAY : RESP_SLVERR;
      s_rlast  <= (r_left == 9'd1);
    end else if (r_fire) begin
      s_rvalid <= 1'b0;
    end
  end

  // Saturating SLVERR counter; a write response and an illegal AR may land together.
  always_ff @(posedge clk_100Mhz) begin
    if (rst)             err_count <= 16'd0;
    else if (err_sum[16]) err_count <= 16'hFFFF;
    else                 err_count <= err_sum[15:0];
  end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// tb/tb_axi4_mem_responder.sv - directed plus randomized bench for axi4_mem_responder
module tb_axi4_mem_responder;

  localparam logic [31:0] BASE   = 32'h0100_0000;
  localparam longint      WINSZ  = 64'd2097152;
  localparam int          BUDGET = 200;

  logic        clk_100Mhz = 1'b0;
  logic        rst = 1'b1;
  logic        stall_en = 1'b0;
  logic [31:0] s_awaddr = '0;
  logic [7:0]  s_awlen = '0;
  logic [2:0]  s_awsize = '0;
  logic [1:0]  s_awburst = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [63:0] s_wdata = '0;
  logic [7:0]  s_wstrb = '0;
  logic        s_wlast = 1'b0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [31:0] s_araddr = '0;
  logic [7:0]  s_arlen = '0;
  logic [2:0]  s_arsize = '0;
  logic [1:0]  s_arburst = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [15:0] err_count;

  int errors = 0;
  int checks = 0;
  int exp_err = 0;

  logic [63:0] ref_mem [int unsigned];
  logic [63:0] wbuf [256];
  logic [7:0]  sbuf [256];

  axi4_mem_responder #(.BASE_ADDR(BASE), .ADDR_BITS(21)) dut (
    .clk_100Mhz(clk_100Mhz), .rst(rst), .stall_en(stall_en),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .err_count(err_count)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_100Mhz);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input logic [31:0] addr, input int len, input int size, input int burst);
    longint s, last;
    s    = longint'(addr);
    last = (s / 8) * 8 + longint'(len) * 8;
    return (burst == 1) && (size == 3) &&
           (s >= longint'(BASE)) && (s < longint'(BASE) + WINSZ) &&
           (last >= longint'(BASE)) && (last < longint'(BASE) + WINSZ) &&
           ((s / 4096) == (last / 4096));
  endfunction

  function automatic int unsigned model_word(input logic [31:0] addr);
    return int'((longint'(addr) - longint'(BASE)) / 8);
  endfunction

  task automatic model_store(input int unsigned k, input logic [63:0] d, input logic [7:0] strb);
    logic [63:0] cur;
    cur = ref_mem.exists(k) ? ref_mem[k] : 64'hx;
    for (int b = 0; b < 8; b++) if (strb[b]) cur[8*b +: 8] = d[8*b +: 8];
    ref_mem[k] = cur;
  endtask

  // rst_at >= 0 aborts the burst with a reset pulse presented on that beat.
  task automatic axi_write(input logic [31:0] addr, input int len, input int size, input int burst,
                           input int bad_last, input int rst_at, input bit rand_b, input bit chk_timing);
    int n;
    bit legal;
    logic [1:0] exp_resp;
    legal = model_legal(addr, len, size, burst);
    s_awaddr = addr; s_awlen = 8'(len); s_awsize = 3'(size); s_awburst = 2'(burst); s_awvalid = 1'b1;
    for (n = 0; n < BUDGET && !s_awready; n++) step();
    check("aw_ready_wait", s_awready, 1);
    step();
    s_awvalid = 1'b0;
    check("aw_ready_drop", s_awready, 0);
    if (chk_timing) check("w_ready_rise", s_wready, 1);
    for (int i = 0; i <= len; i++) begin
      s_wdata = wbuf[i]; s_wstrb = sbuf[i];
      s_wlast = (i == len) ^ (i == bad_last);
      s_wvalid = 1'b1;
      if (i == rst_at) begin
        rst = 1'b1;
        step();
        check("rst_wready", s_wready, 0);
        check("rst_bvalid", s_bvalid, 0);
        rst = 1'b0; s_wvalid = 1'b0; s_wlast = 1'b0;
        step();
        check("rst_awready", s_awready, 1);
        check("rst_err_count", err_count, 0);
        exp_err = 0;
        return;
      end
      for (n = 0; n < BUDGET && !s_wready; n++) step();
      check("w_ready_wait", s_wready, 1);
      step();
      if (legal) model_store(model_word(addr) + i, wbuf[i], sbuf[i]);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    check("b_valid_rise", s_bvalid, 1);
    exp_resp = (legal && bad_last < 0) ? 2'b00 : 2'b10;
    if (exp_resp == 2'b10) exp_err++;
    for (n = 0; n < BUDGET; n++) begin
      s_bready = rand_b ? 1'($urandom_range(0, 1)) : 1'b1;
      check("b_valid_held", s_bvalid, 1);
      check("b_resp", s_bresp, exp_resp);
      if (s_bready) break;
      step();
    end
    step();
    s_bready = 1'b0;
    check("b_valid_fall", s_bvalid, 0);
    check("aw_ready_back", s_awready, 1);
    check("err_count_w", err_count, exp_err);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input int size, input int burst,
                          input bit rand_r, input bit chk_timing);
    int n, lat, beat;
    bit legal, holding, seen;
    logic [63:0] hdata, exp_d;
    logic [1:0]  hresp;
    logic        hlast;
    legal = model_legal(addr, len, size, burst);
    if (!legal) exp_err++;
    s_araddr = addr; s_arlen = 8'(len); s_arsize = 3'(size); s_arburst = 2'(burst); s_arvalid = 1'b1;
    for (n = 0; n < BUDGET && !s_arready; n++) step();
    check("ar_ready_wait", s_arready, 1);
    step();
    s_arvalid = 1'b0;
    check("ar_ready_drop", s_arready, 0);
    lat = 1; beat = 0; holding = 0; seen = 0;
    hdata = '0; hresp = '0; hlast = 1'b0;
    for (n = 0; n < 4 * BUDGET && beat <= len; n++) begin
      s_rready = rand_r ? 1'($urandom_range(0, 1)) : 1'b1;
      if (holding) begin
        check("r_hold_valid", s_rvalid, 1);
        check("r_hold_data", s_rdata, hdata);
        check("r_hold_resp", s_rresp, hresp);
        check("r_hold_last", s_rlast, hlast);
      end
      if (s_rvalid) begin
        if (chk_timing && !seen) check("r_first_latency", lat, 2);
        seen = 1;
        if (s_rready) begin
          exp_d = legal ? ref_mem[model_word(addr) + beat] : 64'd0;
          check("r_data", s_rdata, exp_d);
          check("r_resp", s_rresp, legal ? 2'b00 : 2'b10);
          check("r_last", s_rlast, beat == len);
          beat++;
          holding = 0;
        end else begin
          holding = 1; hdata = s_rdata; hresp = s_rresp; hlast = s_rlast;
        end
      end
      step();
      lat++;
    end
    s_rready = 1'b0;
    check("r_beat_count", beat, len + 1);
    check("r_valid_fall", s_rvalid, 0);
    check("ar_ready_back", s_arready, 1);
    check("err_count_r", err_count, exp_err);
  endtask

  initial begin
    // reset values
    repeat (3) step();
    check("rst_awready", s_awready, 0);
    check("rst_wready", s_wready, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_bresp", s_bresp, 0);
    check("rst_arready", s_arready, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_rlast", s_rlast, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_rresp", s_rresp, 0);
    check("rst_err_count", err_count, 0);
    rst = 1'b0;
    step();
    check("post_rst_awready", s_awready, 1);
    check("post_rst_arready", s_arready, 1);

    // 16-beat incrementing burst and its readback
    for (int i = 0; i < 16; i++) begin wbuf[i] = 64'(i); sbuf[i] = 8'hFF; end
    axi_write(BASE, 15, 3, 1, -1, -1, 0, 1);
    axi_read(BASE, 15, 3, 1, 0, 1);

    // byte-strobe merge
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'hFF;
    axi_write(BASE + 32'h1000, 0, 3, 1, -1, -1, 0, 1);
    wbuf[0] = 64'h0; sbuf[0] = 8'h0F;
    axi_write(BASE + 32'h1000, 0, 3, 1, -1, -1, 0, 1);
    axi_read(BASE + 32'h1000, 0, 3, 1, 0, 1);
    check("strobe_merge_model", ref_mem[model_word(BASE + 32'h1000)], 64'hFFFF_FFFF_0000_0000);

    // outside the window
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    axi_write(32'h0020_0000, 3, 3, 1, -1, -1, 0, 1);
    axi_read(32'h0020_0000, 3, 3, 1, 0, 1);

    // 4 KiB crossing, early WLAST, bad size and burst type
    axi_write(BASE + 32'h0FF8, 1, 3, 1, -1, -1, 0, 1);
    axi_read(BASE + 32'h0FF8, 1, 3, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    axi_write(BASE + 32'h0100, 3, 3, 1, 0, -1, 0, 1);
    axi_read(BASE + 32'h0100, 3, 3, 1, 0, 1);
    axi_write(BASE + 32'h0200, 1, 2, 1, -1, -1, 0, 1);
    axi_read(BASE + 32'h0100, 3, 3, 2, 0, 1);
    axi_read(BASE + 32'h1F_FFF8, 0, 3, 1, 0, 1);

    // 640-beat frame with stall and random handshakes
    stall_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 64; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
      axi_write(BASE + 32'h0004_0000 + 32'(k * 512), 63, 3, 1, -1, -1, 1, 0);
    end
    for (int k = 0; k < 10; k++) axi_read(BASE + 32'h0004_0000 + 32'(k * 512), 63, 3, 1, 1, 0);
    stall_en = 1'b0;
    for (int k = 0; k < 3; k++) axi_read(BASE + 32'h0004_0000 + 32'(k * 512), 63, 3, 1, 1, 0);

    // reset in the middle of a write burst, then a clean burst
    for (int i = 0; i < 16; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    axi_write(BASE + 32'h2000, 15, 3, 1, -1, 5, 0, 0);
    for (int i = 0; i < 16; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    axi_write(BASE + 32'h2000, 15, 3, 1, -1, -1, 0, 1);
    axi_read(BASE + 32'h2000, 15, 3, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
